// File: rtl/ppu_timing_arbiter.sv
// PPU dot/line scheduler with mode FSM, LY compare and interrupt strobes, plus the
// VRAM/OAM arbiter that grants the PPU by mode and fences the CPU out of locked regions.
`timescale 1ns/1ps

module ppu_timing_arbiter #(
  parameter int DOTS_PER_LINE = 456,
  parameter int OAM_DOTS      = 80,
  parameter int DRAW_DOTS     = 172,
  parameter int VISIBLE_LINES = 144,
  parameter int TOTAL_LINES   = 154
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        dot_en,
  input  logic        lcd_enable,
  input  logic [7:0]  lyc,
  input  logic [3:0]  stat_sel,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wren,
  input  logic        ppu_vram_req,
  input  logic        ppu_oam_req,
  output logic [1:0]  mode,
  output logic [7:0]  ly,
  output logic [8:0]  dot,
  output logic        lyc_match,
  output logic        cpu_wren_gated,
  output logic        cpu_rd_mask,
  output logic        ppu_vram_read_en,
  output logic        ppu_oam_read_en,
  output logic        vblank_irq,
  output logic        stat_irq
);

  localparam logic [8:0] LP_DOT_LAST  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] LP_OAM_END   = 9'(OAM_DOTS);
  localparam logic [8:0] LP_DRAW_END  = 9'(OAM_DOTS + DRAW_DOTS);
  localparam logic [7:0] LP_LY_LAST   = 8'(TOTAL_LINES - 1);
  localparam logic [7:0] LP_LY_VBLANK = 8'(VISIBLE_LINES);

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_DRAW   = 2'd3
  } mode_e;

  mode_e      r_mode;
  mode_e      w_mode_next;
  mode_e      r_mode_d;
  logic [8:0] r_dot;
  logic [8:0] w_dot_next;
  logic [7:0] r_ly;
  logic [7:0] w_ly_next;
  logic       r_started;
  logic       w_started_next;
  logic       r_lyc_match;
  logic       r_cond_d;
  logic       r_vblank_irq;
  logic       r_stat_irq;
  logic       w_stat_cond;
  logic       w_in_vram;
  logic       w_in_oam;
  logic       w_vram_locked;
  logic       w_oam_locked;
  logic       w_cpu_blocked;

  // r_started is clear until the first dot tick after reset or after the LCD is
  // switched on; that tick places the beam at line 0, dot 0 instead of advancing.
  always_comb begin
    w_dot_next     = r_dot;
    w_ly_next      = r_ly;
    w_started_next = r_started;
    if (!lcd_enable) begin
      w_dot_next     = 9'd0;
      w_ly_next      = 8'd0;
      w_started_next = 1'b0;
    end else if (dot_en) begin
      if (!r_started) begin
        w_dot_next     = 9'd0;
        w_ly_next      = 8'd0;
        w_started_next = 1'b1;
      end else if (r_dot == LP_DOT_LAST) begin
        w_dot_next = 9'd0;
        w_ly_next  = (r_ly == LP_LY_LAST) ? 8'd0 : r_ly + 8'd1;
      end else begin
        w_dot_next = r_dot + 9'd1;
      end
    end
  end

  always_comb begin
    w_mode_next = r_mode;
    if (!lcd_enable) begin
      w_mode_next = MODE_HBLANK;
    end else if (dot_en) begin
      if (w_ly_next >= LP_LY_VBLANK) begin
        w_mode_next = MODE_VBLANK;
      end else if (w_dot_next < LP_OAM_END) begin
        w_mode_next = MODE_OAM;
      end else if (w_dot_next < LP_DRAW_END) begin
        w_mode_next = MODE_DRAW;
      end else begin
        w_mode_next = MODE_HBLANK;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mode <= MODE_HBLANK;
    end else begin
      r_mode <= w_mode_next;
    end
  end

  // The STAT condition only counts while the PPU is actually scanning, so the idle
  // mode-0 state after reset or LCD-on never produces a spurious edge.
  assign w_stat_cond = lcd_enable && r_started &&
                       ((stat_sel[0] && (r_mode == MODE_HBLANK)) ||
                        (stat_sel[1] && (r_mode == MODE_VBLANK)) ||
                        (stat_sel[2] && (r_mode == MODE_OAM))    ||
                        (stat_sel[3] && r_lyc_match));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dot        <= 9'd0;
      r_ly         <= 8'd0;
      r_started    <= 1'b0;
      r_mode_d     <= MODE_HBLANK;
      r_lyc_match  <= 1'b0;
      r_cond_d     <= 1'b0;
      r_vblank_irq <= 1'b0;
      r_stat_irq   <= 1'b0;
    end else begin
      r_dot        <= w_dot_next;
      r_ly         <= w_ly_next;
      r_started    <= w_started_next;
      r_mode_d     <= r_mode;
      r_lyc_match  <= lcd_enable && (w_ly_next == lyc);
      r_cond_d     <= w_stat_cond;
      r_vblank_irq <= lcd_enable && r_started && (r_mode == MODE_VBLANK) &&
                      (r_mode_d != MODE_VBLANK) && (r_ly == LP_LY_VBLANK);
      r_stat_irq   <= w_stat_cond && !r_cond_d;
    end
  end

  // VRAM is 8000-9FFF, OAM is FE00-FE9F; locks follow the registered mode.
  assign w_in_vram     = (cpu_addr[15:13] == 3'b100);
  assign w_in_oam      = (cpu_addr[15:8] == 8'hFE) && (cpu_addr[7:0] < 8'hA0);
  assign w_vram_locked = lcd_enable && (r_mode == MODE_DRAW);
  assign w_oam_locked  = lcd_enable && ((r_mode == MODE_OAM) || (r_mode == MODE_DRAW));
  assign w_cpu_blocked = (w_in_vram && w_vram_locked) || (w_in_oam && w_oam_locked);

  assign mode             = r_mode;
  assign ly               = r_ly;
  assign dot              = r_dot;
  assign lyc_match        = r_lyc_match;
  assign cpu_wren_gated   = cpu_wren && !w_cpu_blocked;
  assign cpu_rd_mask      = w_cpu_blocked;
  assign ppu_vram_read_en = ppu_vram_req && w_vram_locked;
  assign ppu_oam_read_en  = ppu_oam_req && w_oam_locked;
  assign vblank_irq       = r_vblank_irq;
  assign stat_irq         = r_stat_irq;

endmodule

// File: tb/tb_ppu_timing_arbiter.sv
// Bench for ppu_timing_arbiter: directed line/frame sequences, an arbitration vector
// table, and randomized traffic checked each cycle against a frame-position model.
`timescale 1ns/1ps

module tb_ppu_timing_arbiter;

  localparam int DPL   = 456;
  localparam int OAMD  = 80;
  localparam int DRAWD = 172;
  localparam int VIS   = 144;
  localparam int TOT   = 154;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        dot_en = 1'b0;
  logic        lcd_enable = 1'b0;
  logic [7:0]  lyc = 8'd0;
  logic [3:0]  stat_sel = 4'd0;
  logic [15:0] cpu_addr = 16'd0;
  logic        cpu_wren = 1'b0;
  logic        ppu_vram_req = 1'b0;
  logic        ppu_oam_req = 1'b0;
  logic [1:0]  mode;
  logic [7:0]  ly;
  logic [8:0]  dot;
  logic        lyc_match;
  logic        cpu_wren_gated;
  logic        cpu_rd_mask;
  logic        ppu_vram_read_en;
  logic        ppu_oam_read_en;
  logic        vblank_irq;
  logic        stat_irq;

  ppu_timing_arbiter dut (
    .clock(clock), .reset_n(reset_n), .dot_en(dot_en), .lcd_enable(lcd_enable),
    .lyc(lyc), .stat_sel(stat_sel), .cpu_addr(cpu_addr), .cpu_wren(cpu_wren),
    .ppu_vram_req(ppu_vram_req), .ppu_oam_req(ppu_oam_req), .mode(mode), .ly(ly),
    .dot(dot), .lyc_match(lyc_match), .cpu_wren_gated(cpu_wren_gated),
    .cpu_rd_mask(cpu_rd_mask), .ppu_vram_read_en(ppu_vram_read_en),
    .ppu_oam_read_en(ppu_oam_read_en), .vblank_irq(vblank_irq), .stat_irq(stat_irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail = 0;
  int stat_pulses = 0;
  int vbl_pulses = 0;
  int last_stat_ly = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Beam position is one integer through the frame; line/dot/mode derive from it.
  int m_pos;
  bit m_on, m_lycm, m_vbl, m_stat, m_condp, m_vpend;

  task automatic model_reset();
    m_pos = 0; m_on = 0; m_lycm = 0; m_vbl = 0; m_stat = 0; m_condp = 0; m_vpend = 0;
  endtask

  function automatic logic [1:0] spec_mode(input int p);
    if (p / DPL >= VIS) return 2'd1;
    if (p % DPL < OAMD) return 2'd2;
    if (p % DPL < OAMD + DRAWD) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [1:0] m_mode();
    return m_on ? spec_mode(m_pos) : 2'd0;
  endfunction

  task automatic model_step();
    bit cond, was_on;
    logic [1:0] md;
    md = m_mode();
    cond = lcd_enable && m_on && ((stat_sel[0] && md == 2'd0) || (stat_sel[1] && md == 2'd1) ||
                                  (stat_sel[2] && md == 2'd2) || (stat_sel[3] && m_lycm));
    m_stat  = cond && !m_condp;
    m_condp = cond;
    m_vbl   = m_vpend && lcd_enable && m_on;
    was_on  = m_on;
    if (!lcd_enable) begin
      m_on = 0; m_pos = 0;
    end else if (dot_en) begin
      if (!m_on) begin
        m_on = 1; m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % (DPL * TOT);
      end
    end
    m_vpend = lcd_enable && dot_en && was_on && (m_pos == VIS * DPL);
    m_lycm  = lcd_enable && ((m_on ? m_pos / DPL : 0) == int'(lyc));
  endtask

  function automatic logic [25:0] model_vec();
    logic [1:0] md;
    logic [7:0] l;
    logic [8:0] d;
    logic vr, oa, lk;
    md = m_mode();
    l  = m_on ? 8'(m_pos / DPL) : 8'd0;
    d  = m_on ? 9'(m_pos % DPL) : 9'd0;
    vr = (cpu_addr >= 16'h8000) && (cpu_addr <= 16'h9FFF);
    oa = (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFE9F);
    lk = lcd_enable && ((vr && md == 2'd3) || (oa && md >= 2'd2));
    return {md, l, d, m_lycm, cpu_wren && !lk, lk,
            lcd_enable && ppu_vram_req && (md == 2'd3),
            lcd_enable && ppu_oam_req && (md >= 2'd2), m_vbl, m_stat};
  endfunction

  function automatic logic [25:0] dut_vec();
    return {mode, ly, dot, lyc_match, cpu_wren_gated, cpu_rd_mask,
            ppu_vram_read_en, ppu_oam_read_en, vblank_irq, stat_irq};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    if (reset_n) model_step();
    #1;
    check("cycle", 32'(dut_vec()), 32'(model_vec()));
    if (stat_irq) begin
      stat_pulses++;
      last_stat_ly = int'(ly);
    end
    if (vblank_irq) vbl_pulses++;
  endtask

  task automatic rand_cpu();
    case ($urandom_range(0, 3))
      0: cpu_addr = 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
      1: cpu_addr = 16'hFE00 + 16'($urandom_range(0, 16'hBF));
      2: cpu_addr = 16'($urandom_range(0, 16'hFFFF));
      default: cpu_addr = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'hA000;
    endcase
    cpu_wren     = 1'($urandom_range(0, 1));
    ppu_vram_req = 1'($urandom_range(0, 1));
    ppu_oam_req  = 1'($urandom_range(0, 1));
  endtask

  // ---------------- arbitration vector table ----------------
  typedef struct {
    logic [1:0]  mode;
    logic [15:0] addr;
    logic        wren, vreq, oreq;
    logic        exp_wg, exp_rm, exp_ve, exp_oe;
  } vec_t;

  vec_t tbl[13];
  int   guard;
  int   win_pulses;
  logic [1:0] exp_mode;

  initial begin
    tbl[0]  = '{2'd2, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2'd2, 16'hFE00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{2'd2, 16'hFE9F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{2'd2, 16'h4000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{2'd3, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{2'd3, 16'hFE00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{2'd3, 16'h9FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{2'd3, 16'hA000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{2'd3, 16'hFEA0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{2'd3, 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{2'd0, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{2'd0, 16'hFE00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{2'd0, 16'hFE50, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    model_reset();
    lcd_enable = 1'b1; dot_en = 1'b1; lyc = 8'd5; stat_sel = 4'b1000;
    #2 reset_n = 1'b0;
    tick(); tick();
    check("reset_outputs", 32'(dut_vec()), 32'd0);

    // Line 0 from reset: mode bands and PPU grant windows.
    ppu_vram_req = 1'b1; ppu_oam_req = 1'b1;
    @(negedge clock) reset_n = 1'b1;
    for (int k = 0; k < DPL; k++) begin
      tick();
      exp_mode = (k < OAMD) ? 2'd2 : ((k < OAMD + DRAWD) ? 2'd3 : 2'd0);
      check("line0_mode", 32'(mode), 32'(exp_mode));
      check("line0_oam_grant", 32'(ppu_oam_read_en), 32'(k < OAMD + DRAWD));
      check("line0_vram_grant", 32'(ppu_vram_read_en), 32'(k >= OAMD && k < OAMD + DRAWD));
    end
    tick();
    check("line1_ly", 32'(ly), 32'd1);
    check("line1_dot", 32'(dot), 32'd0);
    check("line1_mode", 32'(mode), 32'd2);

    // Table: walk to each entry's mode, then hold the beam and apply the vector.
    for (int i = 0; i < 13; i++) begin
      dot_en = 1'b1; cpu_wren = 1'b0; ppu_vram_req = 1'b0; ppu_oam_req = 1'b0;
      guard = 0;
      while (mode != tbl[i].mode && guard < 500) begin
        tick();
        guard++;
      end
      check("tbl_mode", 32'(mode), 32'(tbl[i].mode));
      dot_en = 1'b0;
      cpu_addr = tbl[i].addr; cpu_wren = tbl[i].wren;
      ppu_vram_req = tbl[i].vreq; ppu_oam_req = tbl[i].oreq;
      #1;
      check("tbl_wren_gated", 32'(cpu_wren_gated), 32'(tbl[i].exp_wg));
      check("tbl_rd_mask", 32'(cpu_rd_mask), 32'(tbl[i].exp_rm));
      check("tbl_vram_en", 32'(ppu_vram_read_en), 32'(tbl[i].exp_ve));
      check("tbl_oam_en", 32'(ppu_oam_read_en), 32'(tbl[i].exp_oe));
      tick();
    end

    // Random traffic up to mid-draw of line 12, then an asynchronous reset.
    dot_en = 1'b1;
    guard = 0;
    while (!(m_on && m_pos == 12 * DPL + 150) && guard < 10000) begin
      rand_cpu();
      tick();
      guard++;
    end
    check("pre_rst_ly", 32'(ly), 32'd12);
    check("pre_rst_mode", 32'(mode), 32'd3);
    check("lyc_pulse_count", 32'(stat_pulses), 32'd1);
    check("lyc_pulse_ly", 32'(last_stat_ly), 32'd5);
    cpu_addr = 16'h8000; cpu_wren = 1'b0; ppu_vram_req = 1'b1; ppu_oam_req = 1'b1;
    #1;
    check("pre_rst_rd_mask", 32'(cpu_rd_mask), 32'd1);
    check("pre_rst_vram_en", 32'(ppu_vram_read_en), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_vec", 32'(dut_vec()), 32'd0);
    model_reset();
    tick(); tick();
    @(negedge clock) reset_n = 1'b1;

    // LCD toggle 1->0->1 restarts the frame.
    ppu_vram_req = 1'b0; ppu_oam_req = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    lcd_enable = 1'b0;
    tick(); tick(); tick();
    check("lcd_off_ly", 32'(ly), 32'd0);
    check("lcd_off_dot", 32'(dot), 32'd0);
    check("lcd_off_mode", 32'(mode), 32'd0);
    cpu_addr = 16'hFE00; cpu_wren = 1'b1; ppu_vram_req = 1'b1; ppu_oam_req = 1'b1;
    #1;
    check("lcd_off_grants", 32'({ppu_vram_read_en, ppu_oam_read_en}), 32'd0);
    check("lcd_off_wren", 32'(cpu_wren_gated), 32'd1);
    check("lcd_off_rd_mask", 32'(cpu_rd_mask), 32'd0);
    lcd_enable = 1'b1;
    tick();
    check("lcd_restart_vec", 32'({mode, ly, dot}), 32'({2'd2, 8'd0, 9'd0}));

    // Fully random segment: dot_en, LCD, STAT enables and LYC all vary.
    for (int k = 0; k < 400; k++) begin
      rand_cpu();
      dot_en     = 1'($urandom_range(0, 1));
      lcd_enable = ($urandom_range(0, 63) != 0);
      stat_sel   = 4'($urandom_range(0, 15));
      lyc        = 8'($urandom_range(0, 2));
      tick();
    end

    // Full frame with HBlank/VBlank STAT enables.
    lcd_enable = 1'b0;
    tick();
    lcd_enable = 1'b1; dot_en = 1'b1; stat_sel = 4'b0011; lyc = 8'd200;
    vbl_pulses = 0; win_pulses = 0;
    for (int t = 1; t <= TOT * DPL + 1; t++) begin
      rand_cpu();
      tick();
      if (stat_irq && (t - 1) >= 143 * DPL + 252 && (t - 1) < 145 * DPL) win_pulses++;
      if (vblank_irq) begin
        check("vblank_at_ly", 32'(ly), 32'd144);
        check("vblank_at_mode", 32'(mode), 32'd1);
      end
      if (t - 1 == VIS * DPL) begin
        check("vblank_entry_ly", 32'(ly), 32'd144);
        check("vblank_entry_mode", 32'(mode), 32'd1);
      end
    end
    check("frame_wrap_vec", 32'({mode, ly, dot}), 32'({2'd2, 8'd0, 9'd0}));
    check("vblank_pulse_count", 32'(vbl_pulses), 32'd1);
    check("hblank_vblank_stat_pulses", 32'(win_pulses), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
